tblink_rpc_hostproc: RTL

TBLINK_RPC_HOSTPROC -- requirements
Module: tblink_rpc_hostproc

---
 rtl/tblink_rpc_hostproc_if.sv | 53 +++++
 rtl/tblink_rpc_hostproc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tblink_rpc_hostproc_if.sv
`default_nettype none
// ============================================================================
// Module  : tblink_rpc_hostproc_if
// Brief   : Byte streams plus request/response/indication fields of the host
//           RPC processor, with hostproc-side (master) and peer-side (slave) views.
// Revision: 1.0 - initial release
// ============================================================================
interface tblink_rpc_hostproc_if #(
  parameter int REQ_PARAMS_SZ = 1,
  parameter int RSP_SZ        = 1
);
  logic [7:0]                 tx_dat;
  logic                       tx_valid;
  logic                       tx_ready;
  logic [7:0]                 rx_dat;
  logic                       rx_valid;
  logic                       rx_ready;
  logic [7:0]                 req_cmd;
  logic [7:0]                 req_sz;
  logic [8*REQ_PARAMS_SZ-1:0] req_params;
  logic                       req_put_i;
  logic                       req_get_i;
  logic [7:0]                 rsp_sz;
  logic [7:0]                 rsp_id;
  logic [8*RSP_SZ-1:0]        rsp_dat;
  logic [7:0]                 ind_cmd;
  logic [7:0]                 ind_id;
  logic [7:0]                 ind_sz;
  logic [8*RSP_SZ-1:0]        ind_params;
  logic                       ind_put_i;
  logic                       ind_get_i;
  logic                       err_id;
  logic                       err_unexp;

  modport master (
    output tx_dat, tx_valid, input tx_ready,
    input  rx_dat, rx_valid, output rx_ready,
    input  req_cmd, req_sz, req_params, req_put_i, output req_get_i,
    output rsp_sz, rsp_id, rsp_dat,
    output ind_cmd, ind_id, ind_sz, ind_params, ind_put_i, input ind_get_i,
    output err_id, err_unexp
  );

  modport slave (
    input  tx_dat, tx_valid, output tx_ready,
    output rx_dat, rx_valid, input rx_ready,
    output req_cmd, req_sz, req_params, req_put_i, input req_get_i,
    input  rsp_sz, rsp_id, rsp_dat,
    input  ind_cmd, ind_id, ind_sz, ind_params, ind_put_i, output ind_get_i,
    input  err_id, err_unexp
  );
endinterface
`default_nettype wire

// File: rtl/tblink_rpc_hostproc.sv
`default_nettype none
// ============================================================================
// Module  : tblink_rpc_hostproc
// Brief   : Host-side RPC framer: sends requests/indication replies as byte
//           frames and parses response/indication frames from the device.
// Revision: 1.0 - initial release
// ============================================================================
module tblink_rpc_hostproc #(
  parameter int REQ_PARAMS_SZ = 1,
  parameter int RSP_SZ        = 1
) (
  input  logic                 uclock,
  input  logic                 reset,
  tblink_rpc_hostproc_if.master bus
);

  typedef enum logic [2:0] {TX_IDLE, TX_SZ, TX_CMD, TX_ID, TX_DAT} tx_state_t;
  typedef enum logic [2:0] {RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT, RX_DONE, RX_IND_WAIT} rx_state_t;

  tx_state_t                  r_tx_state;
  logic [7:0]                 r_tx_dat;
  logic                       r_tx_valid;
  logic                       r_tx_reply;
  logic [7:0]                 r_req_cmd;
  logic [7:0]                 r_req_sz;
  logic [8*REQ_PARAMS_SZ-1:0] r_req_params;
  logic [7:0]                 r_tx_idx;
  logic [7:0]                 r_req_id;
  logic [7:0]                 r_exp_id;
  logic                       r_outstanding;

  rx_state_t                  r_rx_state;
  logic [7:0]                 r_rx_ndat;
  logic [7:0]                 r_rx_k;
  logic [7:0]                 r_rx_cmd;
  logic [7:0]                 r_rx_id;
  logic [8*RSP_SZ-1:0]        r_rx_data;
  logic [7:0]                 r_rsp_sz;
  logic [7:0]                 r_rsp_id;
  logic [8*RSP_SZ-1:0]        r_rsp_dat;
  logic [7:0]                 r_ind_cmd;
  logic [7:0]                 r_ind_id;
  logic [7:0]                 r_ind_sz;
  logic [8*RSP_SZ-1:0]        r_ind_params;
  logic                       r_ind_put;
  logic                       r_req_get;
  logic                       r_err_id;
  logic                       r_err_unexp;

  logic       w_tx_fire;
  logic       w_rx_fire;
  logic       w_reply_pend;
  logic       w_req_pend;
  logic       w_tx_last;
  logic       w_req_done;
  logic       w_reply_done;
  logic       w_rsp_accept;
  logic [7:0] w_next_idx;
  logic [7:0] w_next_byte;

  assign w_tx_fire    = r_tx_valid & bus.tx_ready;
  assign w_rx_fire    = bus.rx_valid & bus.rx_ready;
  // Reply is owed once the host has taken the indication (toggles match again)
  assign w_reply_pend = (r_rx_state == RX_IND_WAIT) && (r_ind_put == bus.ind_get_i);
  assign w_req_pend   = (bus.req_put_i != r_req_get);
  assign w_tx_last    = w_tx_fire &&
                        (((r_tx_state == TX_ID) && (r_tx_reply || (r_req_sz == 8'd0))) ||
                         ((r_tx_state == TX_DAT) && (r_tx_idx == 8'd0)));
  assign w_req_done   = w_tx_last && !r_tx_reply;
  assign w_reply_done = w_tx_last && r_tx_reply;
  assign w_rsp_accept = (r_rx_state == RX_DONE) && (r_rx_cmd == 8'd0) && r_outstanding;
  assign w_next_idx   = (r_tx_state == TX_ID) ? (r_req_sz - 8'd1) : (r_tx_idx - 8'd1);

  // Parameter bytes past the captured width are sent as zero
  always_comb begin
    w_next_byte = 8'd0;
    for (int k = 0; k < REQ_PARAMS_SZ; k++) begin
      if (w_next_idx == 8'(k)) w_next_byte = r_req_params[8*k +: 8];
    end
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      r_tx_state    <= TX_IDLE;
      r_tx_dat      <= 8'd0;
      r_tx_valid    <= 1'b0;
      r_tx_reply    <= 1'b0;
      r_req_cmd     <= 8'd0;
      r_req_sz      <= 8'd0;
      r_req_params  <= '0;
      r_tx_idx      <= 8'd0;
      r_req_id      <= 8'd0;
      r_exp_id      <= 8'd0;
      r_outstanding <= 1'b0;
    end else begin
      if (w_rsp_accept) r_outstanding <= 1'b0;
      if (w_req_done)   r_outstanding <= 1'b1;
      case (r_tx_state)
        TX_IDLE: begin
          if (w_reply_pend) begin
            r_tx_reply <= 1'b1;
            r_tx_dat   <= 8'd1;
            r_tx_valid <= 1'b1;
            r_tx_state <= TX_SZ;
          end else if (w_req_pend && !r_outstanding) begin
            r_tx_reply   <= 1'b0;
            r_req_cmd    <= bus.req_cmd;
            r_req_sz     <= bus.req_sz;
            r_req_params <= bus.req_params;
            r_tx_dat     <= bus.req_sz + 8'd1;
            r_tx_valid   <= 1'b1;
            r_tx_state   <= TX_SZ;
          end
        end
        TX_SZ: if (w_tx_fire) begin
          r_tx_dat   <= r_tx_reply ? 8'd0 : r_req_cmd;
          r_tx_state <= TX_CMD;
        end
        TX_CMD: if (w_tx_fire) begin
          if (r_tx_reply) begin
            r_tx_dat <= r_ind_id;
          end else begin
            r_tx_dat <= r_req_id;
            r_exp_id <= r_req_id;
            r_req_id <= r_req_id + 8'd1;
          end
          r_tx_state <= TX_ID;
        end
        TX_ID, TX_DAT: if (w_tx_fire) begin
          if (w_tx_last) begin
            r_tx_valid <= 1'b0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_dat   <= w_next_byte;
            r_tx_idx   <= w_next_idx;
            r_tx_state <= TX_DAT;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      r_rx_state   <= RX_DST;
      r_rx_ndat    <= 8'd0;
      r_rx_k       <= 8'd0;
      r_rx_cmd     <= 8'd0;
      r_rx_id      <= 8'd0;
      r_rx_data    <= '0;
      r_rsp_sz     <= 8'd0;
      r_rsp_id     <= 8'd0;
      r_rsp_dat    <= '0;
      r_ind_cmd    <= 8'd0;
      r_ind_id     <= 8'd0;
      r_ind_sz     <= 8'd0;
      r_ind_params <= '0;
      r_ind_put    <= 1'b0;
      r_req_get    <= 1'b0;
      r_err_id     <= 1'b0;
      r_err_unexp  <= 1'b0;
    end else begin
      r_err_id    <= 1'b0;
      r_err_unexp <= 1'b0;
      case (r_rx_state)
        RX_DST: if (w_rx_fire) r_rx_state <= RX_SZ;
        RX_SZ: if (w_rx_fire) begin
          r_rx_ndat  <= (bus.rx_dat == 8'd0) ? 8'd0 : (bus.rx_dat - 8'd1);
          r_rx_data  <= '0;
          r_rx_k     <= 8'd0;
          r_rx_state <= RX_CMD;
        end
        RX_CMD: if (w_rx_fire) begin
          r_rx_cmd   <= bus.rx_dat;
          r_rx_state <= RX_ID;
        end
        RX_ID: if (w_rx_fire) begin
          r_rx_id    <= bus.rx_dat;
          r_rx_state <= (r_rx_ndat == 8'd0) ? RX_DONE : RX_DAT;
        end
        RX_DAT: if (w_rx_fire) begin
          // Bytes beyond the data register width are consumed but not stored
          for (int k = 0; k < RSP_SZ; k++) begin
            if (r_rx_k == 8'(k)) r_rx_data[8*k +: 8] <= bus.rx_dat;
          end
          r_rx_k <= r_rx_k + 8'd1;
          if ((r_rx_k + 8'd1) == r_rx_ndat) r_rx_state <= RX_DONE;
        end
        RX_DONE: begin
          if (r_rx_cmd == 8'd0) begin
            if (r_outstanding) begin
              r_rsp_sz  <= r_rx_ndat;
              r_rsp_id  <= r_rx_id;
              r_rsp_dat <= r_rx_data;
              r_req_get <= ~r_req_get;
              r_err_id  <= (r_rx_id != r_exp_id);
            end else begin
              r_err_unexp <= 1'b1;
            end
            r_rx_state <= RX_DST;
          end else begin
            r_ind_cmd    <= r_rx_cmd;
            r_ind_id     <= r_rx_id;
            r_ind_sz     <= r_rx_ndat;
            r_ind_params <= r_rx_data;
            r_ind_put    <= ~r_ind_put;
            r_rx_state   <= RX_IND_WAIT;
          end
        end
        RX_IND_WAIT: if (w_reply_done) r_rx_state <= RX_DST;
        default: r_rx_state <= RX_DST;
      endcase
    end
  end

  assign bus.tx_dat     = r_tx_dat;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.rx_ready   = (r_rx_state != RX_DONE) && (r_rx_state != RX_IND_WAIT);
  assign bus.req_get_i  = r_req_get;
  assign bus.rsp_sz     = r_rsp_sz;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_dat    = r_rsp_dat;
  assign bus.ind_cmd    = r_ind_cmd;
  assign bus.ind_id     = r_ind_id;
  assign bus.ind_sz     = r_ind_sz;
  assign bus.ind_params = r_ind_params;
  assign bus.ind_put_i  = r_ind_put;
  assign bus.err_id     = r_err_id;
  assign bus.err_unexp  = r_err_unexp;

endmodule
`default_nettype wire
